// File: rtl/fir_stream_driver.sv
// Host-to-FIR transmit driver: gathers TAPS coefficients, bursts them to the filter, then streams samples.
// Optional build macro FIR_DRV_RESCNT_EN adds a saturating res_count output.
module fir_stream_driver #(
    parameter int TAPS = 5,
    parameter int CW   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [7:0]  smp_data,
    input  logic        smp_valid,
    output logic        smp_ready,
    output logic [7:0]  fir_data,
    output logic        fir_coef_enable,
    output logic        fir_sample_enable,
    input  logic [15:0] fir_result,
    input  logic        fir_out_enable,
    input  logic        fir_error,
    output logic [15:0] res_data,
    output logic        res_valid,
    output logic        busy,
    output logic        err
`ifdef FIR_DRV_RESCNT_EN
    ,
    output logic [15:0] res_count
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_BURST   = 3'd2;
    localparam logic [2:0] ST_STREAM  = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;

    localparam logic [CW-1:0] LAST_IDX = CW'(TAPS - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] index_q, index_d;
    logic [7:0]    bank_q [TAPS];
    logic [7:0]    bank_d [TAPS];
    logic [7:0]    fir_data_q, fir_data_d;
    logic          coef_en_q, coef_en_d;
    logic          smp_en_q, smp_en_d;
    logic [15:0]   res_data_q, res_data_d;
    logic          res_valid_q, res_valid_d;

    logic fault;
    logic cfg_hs;
    logic smp_hs;

    // A sample issued without a matching result is as fatal as the filter's own error.
    assign fault = fir_error || (smp_en_q && !fir_out_enable);

    assign cfg_ready = reset && !fault &&
                       ((state_q == ST_IDLE) || (state_q == ST_COLLECT) || (state_q == ST_STREAM));
    assign smp_ready = reset && !fault && (state_q == ST_STREAM) && !cfg_valid;

    assign cfg_hs = cfg_valid && cfg_ready;
    assign smp_hs = smp_valid && smp_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        index_d     = index_q;
        bank_d      = bank_q;
        fir_data_d  = '0;
        coef_en_d   = 1'b0;
        smp_en_d    = 1'b0;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;

        if (smp_en_q && fir_out_enable) begin
            res_data_d  = fir_result;
            res_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_hs) begin
                    bank_d[0] = cfg_data;
                    index_d   = CW'(1);
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (cfg_hs) begin
                    bank_d[index_q] = cfg_data;
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = ST_BURST;
                    end else begin
                        index_d = index_q + CW'(1);
                    end
                end
            end
            ST_BURST: begin
                coef_en_d  = 1'b1;
                fir_data_d = bank_q[index_q];
                if (index_q == LAST_IDX) begin
                    index_d = '0;
                    state_d = ST_STREAM;
                end else begin
                    index_d = index_q + CW'(1);
                end
            end
            ST_STREAM: begin
                // A coefficient arriving here restarts the load; smp_ready is already held low.
                if (cfg_hs) begin
                    bank_d[0] = cfg_data;
                    index_d   = CW'(1);
                    state_d   = ST_COLLECT;
                end else if (smp_hs) begin
                    smp_en_d   = 1'b1;
                    fir_data_d = smp_data;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase

        if (fault) begin
            state_d    = ST_ERROR;
            coef_en_d  = 1'b0;
            smp_en_d   = 1'b0;
            fir_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            // NOTE: the coefficient bank is small and architecturally visible, so it is cleared too.
            for (int i = 0; i < TAPS; i++) begin
                bank_q[i] <= '0;
            end
            fir_data_q  <= '0;
            coef_en_q   <= 1'b0;
            smp_en_q    <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state_q     <= state_d;
            index_q     <= index_d;
            bank_q      <= bank_d;
            fir_data_q  <= fir_data_d;
            coef_en_q   <= coef_en_d;
            smp_en_q    <= smp_en_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef FIR_DRV_RESCNT_EN
    logic [15:0] res_count_q;
    logic        reload_start;

    assign reload_start = cfg_hs && (state_q == ST_STREAM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_count_q <= '0;
        end else if (reload_start) begin
            res_count_q <= '0;
        end else if (res_valid_q && (res_count_q != 16'hFFFF)) begin
            res_count_q <= res_count_q + 16'd1;
        end
    end

    assign res_count = res_count_q;
`endif

    assign fir_data          = fir_data_q;
    assign fir_coef_enable   = coef_en_q;
    assign fir_sample_enable = smp_en_q;
    assign res_data          = res_data_q;
    assign res_valid         = res_valid_q;
    // The final burst cycle is shown after the state has already moved on.
    assign busy              = (state_q == ST_COLLECT) || (state_q == ST_BURST) || coef_en_q;
    assign err               = (state_q == ST_ERROR);

endmodule
